// File: rtl/arch_regfile_rd_arbiter.sv
// Round-robin arbiter that shares the architectural regfile read port among
// NUM_REQ requesters. Only one read is in flight at a time, and the read value
// is held in a response register until its owner accepts it.

`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module arch_regfile_rd_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = `ARCH_REG_NUM_WIDTH,
    parameter int unsigned DATA_W  = `REG_VAL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      rf_rd_en,
    output logic [ADDR_W-1:0]         rf_rd_addr,
    input  logic [DATA_W-1:0]         rf_rd_value,
    input  logic                      rf_rd_valid,
    output logic                      busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    typedef enum logic {StIdle, StResp} state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [DATA_W-1:0]  rsp_data_q;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   next_ptr;
    logic [SUM_W-1:0]   cand;
    logic               grant;

    // Pick the first valid requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = SUM_W'(rr_ptr_q) + SUM_W'(off);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    // Pointer advances to the slot just past the winner, wrapping to 0.
    always_comb begin
        if (winner == PTR_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + PTR_W'(1);
        end
    end

    // Regfile request and grant; a grant only happens when the regfile returns data.
    always_comb begin
        req_ready  = '0;
        rf_rd_en   = 1'b0;
        rf_rd_addr = '0;
        if (state_q == StIdle && found && !flush) begin
            rf_rd_en          = 1'b1;
            rf_rd_addr        = req_addr[winner*ADDR_W +: ADDR_W];
            req_ready[winner] = rf_rd_valid;
        end
    end

    assign grant = (state_q == StIdle) && found && rf_rd_valid && !flush;

    // Response side is driven purely from registered state, so rsp_ready never
    // reaches req_ready combinationally.
    always_comb begin
        rsp_valid = '0;
        if (state_q == StResp) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign busy     = (state_q == StResp);
    assign rsp_data = rsp_data_q;

    // Arbiter FSM: capture the read value at grant, hold it until the owner accepts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            rsp_data_q <= '0;
        end else if (flush) begin
            // Pending response is dropped; rr_ptr keeps its value.
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        rsp_data_q <= rf_rd_value;
                        owner_q    <= winner;
                        rr_ptr_q   <= next_ptr;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready[owner_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arch_regfile_rd_arbiter.sv
// Bench for arch_regfile_rd_arbiter: directed stimulus, a small regfile model
// with same-cycle commit forwarding, and a scoreboard drained by a monitor.

module tb_arch_regfile_rd_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic                      rf_rd_en;
    logic [ADDR_W-1:0]         rf_rd_addr;
    logic [DATA_W-1:0]         rf_rd_value;
    logic                      rf_rd_valid;
    logic                      busy;

    // Regfile model: unwritten registers read back their own index.
    logic                      commit_en;
    logic [ADDR_W-1:0]         commit_addr;
    logic [DATA_W-1:0]         commit_data;
    logic [DATA_W-1:0]         regs [32];
    bit                        written [32];

    int n_checks;
    int n_fail;
    int exp_owner [$];
    logic [DATA_W-1:0] exp_data [$];

    arch_regfile_rd_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_value (rf_rd_value),
        .rf_rd_valid (rf_rd_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile commit write port.
    always @(posedge clk) begin
        if (commit_en) begin
            regs[commit_addr]    <= commit_data;
            written[commit_addr] <= 1'b1;
        end
    end

    // Combinational read with same-cycle commit forwarding.
    always_comb begin
        if (commit_en && commit_addr == rf_rd_addr) begin
            rf_rd_value = commit_data;
        end else if (written[rf_rd_addr]) begin
            rf_rd_value = regs[rf_rd_addr];
        end else begin
            rf_rd_value = DATA_W'(rf_rd_addr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input int owner, input logic [DATA_W-1:0] data);
        exp_owner.push_back(owner);
        exp_data.push_back(data);
    endtask

    // Pops one expected response per accepted (non-flushed) handshake.
    task automatic monitor();
        int o;
        logic [DATA_W-1:0] d;
        logic [NUM_REQ-1:0] onehot;
        forever begin
            @(negedge clk);
            if (reset && !flush && |(rsp_valid & rsp_ready)) begin
                if (exp_owner.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    o = exp_owner.pop_front();
                    d = exp_data.pop_front();
                    onehot = '0;
                    onehot[o] = 1'b1;
                    check("rsp_owner", 64'(rsp_valid), 64'(onehot));
                    check("rsp_data", 64'(rsp_data), 64'(d));
                end
            end
        end
    endtask

    task automatic watchdog();
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "time limit");
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        flush       = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        rsp_ready   = '0;
        rf_rd_valid = 1'b1;
        commit_en   = 1'b0;
        commit_addr = '0;
        commit_data = '0;
        fork
            monitor();
            watchdog();
        join_none

        // Reset values.
        #12;
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_rf_rd_en", 64'(rf_rd_en), 64'(0));
        check("reset_rsp_data", 64'(rsp_data), 64'(0));
        reset = 1'b1;
        step();

        // Requester 2 reads addr 7 alone.
        req_valid = 4'b0100;
        req_addr  = {5'd0, 5'd7, 5'd0, 5'd0};
        expect_rsp(2, 32'd7);
        @(negedge clk);
        check("t1_req_ready", 64'(req_ready), 64'b0100);
        check("t1_rf_addr", 64'(rf_rd_addr), 64'd7);
        check("t1_rf_en", 64'(rf_rd_en), 64'd1);
        step();
        req_valid = '0;
        rsp_ready = 4'b0100;
        @(negedge clk);
        check("t1_busy", 64'(busy), 64'd1);
        step();
        rsp_ready = '0;
        @(negedge clk);
        check("t1_idle", 64'(busy), 64'd0);

        // Reset so the pointer starts at 0, then all four request continuously.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        req_valid = 4'b1111;
        req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        rsp_ready = 4'b1111;
        for (int k = 0; k < 5; k++) expect_rsp(order[k], 32'(order[k] + 1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k % 2 == 0) check("t2_grant", 64'(req_ready), 64'(1) << order[k/2]);
            else            check("t2_gap", 64'(req_ready), 64'd0);
            step();
        end
        req_valid = '0;
        rsp_ready = '0;

        // Requester 1 holds its response while requester 3 waits.
        req_valid = 4'b0010;
        req_addr  = {5'd12, 5'd0, 5'd9, 5'd0};
        expect_rsp(1, 32'd9);
        @(negedge clk);
        check("t3_grant1", 64'(req_ready), 64'b0010);
        step();
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(rsp_valid), 64'b0010);
            check("t3_hold_data", 64'(rsp_data), 64'd9);
            check("t3_hold_noready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 4'b0010;
        expect_rsp(3, 32'd12);
        step();
        rsp_ready = '0;
        @(negedge clk);
        check("t3_grant3", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;

        // Same-cycle commit is forwarded; a later commit is not.
        req_valid   = 4'b0001;
        req_addr    = {5'd0, 5'd0, 5'd0, 5'd5};
        commit_en   = 1'b1;
        commit_addr = 5'd5;
        commit_data = 32'hDEAD;
        expect_rsp(0, 32'hDEAD);
        @(negedge clk);
        check("t4_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid   = '0;
        commit_data = 32'hBEEF;
        @(negedge clk);
        check("t4_data_after_commit", 64'(rsp_data), 64'hDEAD);
        step();
        commit_en = 1'b0;
        rsp_ready = 4'b0001;
        @(negedge clk);
        check("t4_data_held", 64'(rsp_data), 64'hDEAD);
        step();
        rsp_ready = '0;

        // Regfile not ready: no accept, retried next cycle.
        req_valid   = 4'b0001;
        req_addr    = {5'd0, 5'd0, 5'd0, 5'd6};
        rf_rd_valid = 1'b0;
        @(negedge clk);
        check("t5_noaccept", 64'(req_ready), 64'd0);
        check("t5_rf_en", 64'(rf_rd_en), 64'd1);
        check("t5_rf_addr", 64'(rf_rd_addr), 64'd6);
        step();
        rf_rd_valid = 1'b1;
        expect_rsp(0, 32'd6);
        @(negedge clk);
        check("t5_not_busy", 64'(busy), 64'd0);
        check("t5_retry_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;

        // Flush in RESP with owner ready: response dropped, pointer kept.
        req_valid = 4'b0100;
        req_addr  = {5'd0, 5'd3, 5'd0, 5'd0};
        @(negedge clk);
        check("t6_grant2", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        flush     = 1'b1;
        rsp_ready = 4'b0100;
        @(negedge clk);
        check("t6_valid_in_flush", 64'(rsp_valid), 64'b0100);
        step();
        rsp_ready = '0;
        req_valid = 4'b1011;
        req_addr  = {5'd10, 5'd0, 5'd2, 5'd1};
        @(negedge clk);
        check("t6_dropped", 64'(rsp_valid), 64'd0);
        check("t6_flush_blocks_grant", 64'(req_ready), 64'd0);
        step();
        flush = 1'b0;
        expect_rsp(3, 32'd10);
        @(negedge clk);
        check("t6_ptr_kept", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;

        // Asynchronous reset in RESP.
        req_valid = 4'b0010;
        req_addr  = {5'd0, 5'd0, 5'd8, 5'd0};
        @(negedge clk);
        check("t7_grant1", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        #1;
        check("t7_busy_before", 64'(busy), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t7_async_valid", 64'(rsp_valid), 64'd0);
        check("t7_async_busy", 64'(busy), 64'd0);
        check("t7_async_data", 64'(rsp_data), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        step();
        req_valid = 4'b1111;
        req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        expect_rsp(0, 32'd1);
        @(negedge clk);
        check("t7_ptr_zero", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;

        repeat (3) step();
        check("scoreboard_empty", 64'(exp_owner.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
